// File: rtl/cnn_3d_layer_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_3d_layer_sequencer
//   Control FSM for the 3D CNN pipeline. For every filter it runs the conv
//   engine then the pool engine, and after the last filter it runs the FC
//   engine once. Each engine gets a one-cycle start pulse and the sequencer
//   waits for that engine's done. A per-stage watchdog moves the FSM to an
//   error state if an engine never answers.
//
// Handshake: a *_start pulse is high for exactly the first cycle of its
//   stage. The matching *_done is ignored in that first cycle and sampled on
//   every later cycle of the stage; done inputs of other engines are ignored.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   start               run request, sampled only while idle
//   abort               cancel the current run (no effect while idle)
//   conv_done, pool_done, fc_done   engine completion inputs
//   conv_start, pool_start, fc_start  one-cycle start pulses
//   filter_idx          filter currently being processed
//   stage               0 IDLE, 1 CONV, 2 POOL, 3 FC, 4 DONE, 5 ERR
//   busy                stage is not IDLE
//   done                one-cycle completion pulse
//   error               watchdog fired; held until reset or abort
//   cycle_count         active cycles of the last/current run (saturating)
// ---------------------------------------------------------------------------
module cnn_3d_layer_sequencer #(
    parameter int NUM_FILTERS    = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FW             = $clog2(NUM_FILTERS > 1 ? NUM_FILTERS : 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          conv_done,
    input  logic          pool_done,
    input  logic          fc_done,
    output logic          conv_start,
    output logic          pool_start,
    output logic          fc_start,
    output logic [FW-1:0] filter_idx,
    output logic [2:0]    stage,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [31:0]   cycle_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] LAST_FILTER = FW'(NUM_FILTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_FC   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [FW-1:0] r_filter_idx;
    logic          r_conv_start;
    logic          r_pool_start;
    logic          r_fc_start;
    logic          r_done;
    logic          r_error;
    logic [31:0]   r_cycle_count;

    logic w_stage_done;
    logic w_done_seen;
    logic w_timeout;
    logic w_counting;

    // Only the engine that owns the current stage can end it.
    always_comb begin
        w_stage_done = 1'b0;
        case (r_state)
            S_CONV:  w_stage_done = conv_done;
            S_POOL:  w_stage_done = pool_done;
            S_FC:    w_stage_done = fc_done;
            default: w_stage_done = 1'b0;
        endcase
    end

    // The timer is zero only in the entry cycle of a stage, so a non-zero
    // timer doubles as "done may be sampled now".
    assign w_done_seen = w_stage_done && (r_timer != '0);
    assign w_timeout   = (r_timer == TIMEOUT_VAL);
    assign w_counting  = (r_state == S_CONV) || (r_state == S_POOL) ||
                         (r_state == S_FC)   || (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_filter_idx  <= '0;
            r_conv_start  <= 1'b0;
            r_pool_start  <= 1'b0;
            r_fc_start    <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_conv_start <= 1'b0;
            r_pool_start <= 1'b0;
            r_fc_start   <= 1'b0;
            r_done       <= 1'b0;

            if (w_counting && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end

            // Abort outranks stage done and the watchdog.
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_error <= 1'b0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state       <= S_CONV;
                            r_conv_start  <= 1'b1;
                            r_filter_idx  <= '0;
                            r_timer       <= '0;
                            r_cycle_count <= '0;
                        end
                    end
                    S_CONV: begin
                        if (w_done_seen) begin
                            r_state      <= S_POOL;
                            r_pool_start <= 1'b1;
                            r_timer      <= '0;
                        end else if (w_timeout) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_POOL: begin
                        if (w_done_seen) begin
                            r_timer <= '0;
                            if (r_filter_idx != LAST_FILTER) begin
                                r_state      <= S_CONV;
                                r_conv_start <= 1'b1;
                                r_filter_idx <= r_filter_idx + FW'(1);
                            end else begin
                                r_state    <= S_FC;
                                r_fc_start <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_FC: begin
                        if (w_done_seen) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_timer <= '0;
                        end else if (w_timeout) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign conv_start  = r_conv_start;
    assign pool_start  = r_pool_start;
    assign fc_start    = r_fc_start;
    assign filter_idx  = r_filter_idx;
    assign stage       = r_state;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign error       = r_error;
    assign cycle_count = r_cycle_count;

endmodule
